dtw_result_axis_packer: RTL

Parametrised AXI-Stream master that collects narrow DTW result values from the accelerator core and packs them little-endian into TDATA words. It buffers packed words in an internal FIFO, frames them into packets with TLAST every C_PACKET_WORDS words or on an explicit flush, and streams them to the DMA. It replaces the fixed 8-word, 32-bit output master with configurable result width, FIFO depth and packet length. It adds partial-word flush with TSTRB masking, overflow reporting and an occupancy output.

---
 rtl/dtw_result_axis_packer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dtw_result_axis_packer.sv
// Packs narrow DTW results little-endian into AXI-Stream words, buffers them in a FIFO
// and frames packets with TLAST on a word count or an explicit flush.
module dtw_result_axis_packer #(
   parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
   parameter int unsigned C_RESULT_WIDTH       = 8,
   parameter int unsigned C_FIFO_DEPTH         = 16,
   parameter int unsigned C_PACKET_WORDS       = 8
) (
   input  logic                                M_AXIS_ACLK,
   input  logic                                M_AXIS_ARESETN,
   input  logic                                dtw_fifo_wren,
   input  logic [C_RESULT_WIDTH-1:0]           dtw_fifo_din,
   input  logic                                dtw_flush,
   output logic                                dtw_fifo_full,
   output logic [$clog2(C_FIFO_DEPTH):0]       dtw_fifo_count,
   output logic                                dtw_overflow,
   output logic                                M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
   output logic                                M_AXIS_TLAST,
   input  logic                                M_AXIS_TREADY
);

   localparam int unsigned DW    = C_M_AXIS_TDATA_WIDTH;
   localparam int unsigned RW    = C_RESULT_WIDTH;
   localparam int unsigned SW    = DW / 8;
   localparam int unsigned LANES = DW / RW;
   localparam int unsigned LB    = RW / 8;
   localparam int unsigned IW    = $clog2(LANES + 1);
   localparam int unsigned PW    = $clog2(C_FIFO_DEPTH);
   localparam int unsigned CW    = PW + 1;
   localparam int unsigned KW    = (C_PACKET_WORDS > 1) ? $clog2(C_PACKET_WORDS) : 1;
   localparam int unsigned EW    = DW + SW + 1;

   typedef enum logic [0:0] {StRun, StFlushPend} state_e;

   state_e                      state_q, state_d;
   logic [IW-1:0]               idx_q, idx_d, idx_inc;
   logic [LANES-1:0][RW-1:0]    hold_q, hold_d, lanes;
   logic [KW-1:0]               pkt_q, pkt_d;
   logic [PW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        full_q, full_d;
   logic                        ovf_q, ovf_d;
   logic                        tvalid_q, tlast_q;
   logic [DW-1:0]               tdata_q;
   logic [SW-1:0]               tstrb_q;

   logic                        accept, word_done, do_flush, pkt_last;
   logic                        push, push_last, pop;
   logic [DW-1:0]               push_data;
   logic [SW-1:0]               push_strb, part_strb;
   logic [EW-1:0]               mem [C_FIFO_DEPTH];
   logic [EW-1:0]               rd_entry;

   assign accept   = dtw_fifo_wren && !full_q;
   assign pkt_last = (pkt_q == KW'(C_PACKET_WORDS - 1));
   assign rd_entry = mem[rptr_q];

   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      do_flush  = 1'b0;
      lanes     = hold_q;
      part_strb = '0;
      push      = 1'b0;
      push_data = '0;
      push_strb = '0;
      push_last = 1'b0;

      unique case (state_q)
         StRun: begin
            if (dtw_flush) begin
               if (full_q) state_d = StFlushPend;
               else        do_flush = 1'b1;
            end
         end
         StFlushPend: begin
            if (count_q != CW'(C_FIFO_DEPTH)) begin
               do_flush = 1'b1;
               state_d  = StRun;
            end
         end
      endcase

      // The incoming result is merged before any flush so it lands in the flushed word.
      for (int i = 0; i < LANES; i++) begin
         if (accept && idx_q == IW'(i)) lanes[i] = dtw_fifo_din;
      end
      idx_inc   = idx_q + IW'(accept);
      word_done = (idx_inc == IW'(LANES));
      for (int i = 0; i < LANES; i++) begin
         if (IW'(i) < idx_inc) part_strb[i*LB +: LB] = '1;
      end

      idx_d  = idx_inc;
      hold_d = lanes;
      if (word_done) begin
         push      = 1'b1;
         push_data = lanes;
         push_strb = '1;
         push_last = do_flush || pkt_last;
         idx_d     = '0;
         hold_d    = '0;
      end else if (do_flush && idx_inc != '0) begin
         push      = 1'b1;
         push_data = lanes;
         push_strb = part_strb;
         push_last = 1'b1;
         idx_d     = '0;
         hold_d    = '0;
      end else if (do_flush && pkt_q != '0) begin
         push      = 1'b1;
         push_last = 1'b1;
      end

      pkt_d = pkt_q;
      if (push) pkt_d = push_last ? '0 : pkt_q + KW'(1);

      pop     = (count_q != '0) && (!tvalid_q || M_AXIS_TREADY);
      wptr_d  = wptr_q + PW'(push);
      rptr_d  = rptr_q + PW'(pop);
      count_d = count_q + CW'(push) - CW'(pop);
      full_d  = (count_d == CW'(C_FIFO_DEPTH)) || (state_d == StFlushPend);
      ovf_d   = ovf_q || (dtw_fifo_wren && full_q);
   end

   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         idx_q   <= '0;
         hold_q  <= '0;
         pkt_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         pkt_q   <= pkt_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge M_AXIS_ACLK) begin
      if (push) mem[wptr_q] <= {push_last, push_strb, push_data};
   end

   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tstrb_q  <= '0;
         tdata_q  <= '0;
      end else if (pop) begin
         tvalid_q <= 1'b1;
         tlast_q  <= rd_entry[EW-1];
         tstrb_q  <= rd_entry[DW +: SW];
         tdata_q  <= rd_entry[DW-1:0];
      end else if (M_AXIS_TREADY) begin
         tvalid_q <= 1'b0;
      end
   end

   assign dtw_fifo_full  = full_q;
   assign dtw_fifo_count = count_q;
   assign dtw_overflow   = ovf_q;
   assign M_AXIS_TVALID  = tvalid_q;
   assign M_AXIS_TDATA   = tdata_q;
   assign M_AXIS_TSTRB   = tstrb_q;
   assign M_AXIS_TLAST   = tlast_q;

endmodule
